// File: rtl/vector_list_writer_if.sv
// Point stream from the vector producer into vector_list_writer.
// The source side drives the point fields; the writer answers with in_ready.
interface vector_list_writer_if #(
  parameter int XY_WIDTH = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [XY_WIDTH-1:0] in_x;
  logic [XY_WIDTH-1:0] in_y;
  logic                in_draw;
  logic                in_pos;
  logic                in_last;

  modport master (
    output in_valid, in_x, in_y, in_draw, in_pos, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_x, in_y, in_draw, in_pos, in_last,
    output in_ready
  );
endinterface

// File: rtl/vector_list_writer.sv
// Writes a {x,y,draw,pos} point stream into a ping-pong vector RAM; frames commit by bank swap.
// Define VECTOR_SWAP_SYNC_EN to hold each swap until the reader reports the end of a pass (rd_wrap).
module vector_list_writer #(
  parameter int XY_WIDTH     = 8,
  parameter int DEPTH        = 32,
  parameter int ADDRESSWIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      rd_wrap,
  vector_list_writer_if.slave       pt,
  output logic                      we,
  output logic [ADDRESSWIDTH-1:0]   a,
  output logic [2*XY_WIDTH+1:0]     din,
  output logic                      rd_bank,
  output logic [$clog2(DEPTH):0]    frame_len,
  output logic                      frame_done,
  output logic                      overflow
);

  localparam int IW = $clog2(DEPTH);

`ifdef VECTOR_SWAP_SYNC_EN
  typedef enum logic [1:0] {
    FILL      = 2'd0,
    SWAP      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    FILL = 2'd0,
    SWAP = 2'd1
  } state_t;

  logic unused_rd_wrap;
  assign unused_rd_wrap = rd_wrap;
`endif

  state_t      state;
  state_t      state_nxt;
  logic        running;
  logic        wr_bank;
  logic [IW:0] idx;
  logic [IW:0] len;

  logic ready;
  logic accept;
  logic store;
  logic commit;
  logic abort;

  assign pt.in_ready = ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    store     = 1'b0;
    commit    = 1'b0;
    abort     = 1'b0;
    unique case (state)
      FILL: begin
        // running keeps in_ready low for the first cycle out of reset
        ready = running && !clear;
        if (clear) begin
          abort = 1'b1;
        end else if (pt.in_valid && ready) begin
          accept = 1'b1;
          // idx never exceeds DEPTH, so its top bit alone marks a full bank
          store  = !idx[IW];
          if (pt.in_last) begin
`ifdef VECTOR_SWAP_SYNC_EN
            state_nxt = WAIT_SWAP;
`else
            state_nxt = SWAP;
`endif
          end
        end
      end
      SWAP: begin
        commit    = 1'b1;
        state_nxt = FILL;
      end
`ifdef VECTOR_SWAP_SYNC_EN
      WAIT_SWAP: begin
        if (clear) begin
          abort     = 1'b1;
          state_nxt = FILL;
        end else if (rd_wrap) begin
          commit    = 1'b1;
          state_nxt = FILL;
        end
      end
`endif
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running    <= 1'b0;
      we         <= 1'b0;
      a          <= '0;
      din        <= '0;
      rd_bank    <= 1'b1;
      wr_bank    <= 1'b0;
      frame_len  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      idx        <= '0;
      len        <= '0;
    end else begin
      running    <= 1'b1;
      we         <= store;
      frame_done <= commit;
      if (store) begin
        a   <= ADDRESSWIDTH'({wr_bank, idx[IW-1:0]});
        din <= {pt.in_y, pt.in_x, pt.in_draw, pt.in_pos};
        idx <= idx + (IW+1)'(1);
      end
      if (accept && !store) overflow <= 1'b1;
      if (accept && pt.in_last) len <= store ? idx + (IW+1)'(1) : idx;
      if (commit) begin
        rd_bank   <= wr_bank;
        wr_bank   <= ~wr_bank;
        frame_len <= len;
        idx       <= '0;
        overflow  <= 1'b0;
      end
      if (abort) begin
        idx      <= '0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vector_list_writer.sv
// Bench for vector_list_writer: frame-level reference model checked every cycle, plus directed literal checks.
module tb_vector_list_writer;
  localparam int XW = 8;
  localparam int D  = 32;
  localparam int AW = 16;
  localparam int DW = 2*XW+2;
  localparam int LW = $clog2(D)+1;
`ifdef VECTOR_SWAP_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic rd_wrap = 1'b0;
  logic we, rd_bank, frame_done, overflow;
  logic [AW-1:0] a;
  logic [DW-1:0] din;
  logic [LW-1:0] frame_len;

  vector_list_writer_if #(.XY_WIDTH(XW)) pt();

  vector_list_writer #(.XY_WIDTH(XW), .DEPTH(D), .ADDRESSWIDTH(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .rd_wrap(rd_wrap), .pt(pt),
    .we(we), .a(a), .din(din), .rd_bank(rd_bank), .frame_len(frame_len),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame count picks the bank, point count the offset.
  bit          m_live;
  int          m_phase;      // 0 taking points, 1 commit next edge, 2 waiting for reader wrap
  int unsigned m_frames, m_n, m_len, m_flen;
  logic        m_ovf, m_rdb, m_we, m_done;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_din;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_live = 0; m_phase = 0; m_frames = 0; m_n = 0; m_len = 0; m_flen = 0;
      m_ovf = 0; m_rdb = 1; m_we = 0; m_done = 0; m_a = '0; m_din = '0;
    end else begin
      m_we = 0; m_done = 0;
      if (!m_live) m_live = 1;
      else if (m_phase == 1 || (m_phase == 2 && !clear && rd_wrap)) begin
        m_rdb = m_frames[0]; m_frames++; m_flen = m_len;
        m_n = 0; m_ovf = 0; m_done = 1; m_phase = 0;
      end else if (clear) begin
        m_n = 0; m_ovf = 0; m_phase = 0;
      end else if (m_phase == 0 && pt.in_valid) begin
        if (m_n < D) begin
          m_we = 1;
          m_a = AW'((m_frames % 2) * D + m_n);
          m_din = {pt.in_y, pt.in_x, pt.in_draw, pt.in_pos};
          m_n++;
        end else m_ovf = 1;
        if (pt.in_last) begin
          m_len = m_n;
          m_phase = SYNC ? 2 : 1;
        end
      end
    end
  end

  bit cmp_on = 0;
  always @(negedge clk) if (cmp_on) begin
    chk("in_ready",   32'(pt.in_ready), 32'(m_live && m_phase == 0 && !clear));
    chk("we",         32'(we),          32'(m_we));
    chk("a",          32'(a),           32'(m_a));
    chk("din",        32'(din),         32'(m_din));
    chk("rd_bank",    32'(rd_bank),     32'(m_rdb));
    chk("frame_len",  32'(frame_len),   m_flen);
    chk("frame_done", 32'(frame_done),  32'(m_done));
    chk("overflow",   32'(overflow),    32'(m_ovf));
  end

  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  logic          dbank[$];
  int            dn = 0;
  bit            mon = 0;
  int            lowcnt = 0;
  always @(negedge clk) begin
    if (we) begin wa.push_back(a); wd.push_back(din); end
    if (frame_done) begin dn++; dbank.push_back(rd_bank); end
    if (mon && !pt.in_ready) lowcnt++;
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic d, input logic p, input logic l);
    int n = 0;
    logic acc = 1'b0;
    pt.in_valid = 1; pt.in_x = x; pt.in_y = y; pt.in_draw = d; pt.in_pos = p; pt.in_last = l;
    do begin
      @(negedge clk); acc = pt.in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 40);
    if (!acc) chk("send_timeout", 32'(acc), 32'(1));
  endtask

  task automatic idle(input int n);
    pt.in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_logs();
    wa.delete(); wd.delete(); dbank.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pt.in_valid = 0; pt.in_x = '0; pt.in_y = '0; pt.in_draw = 0; pt.in_pos = 0; pt.in_last = 0;
    #1 rst = 0; cmp_on = 1;
    repeat (3) @(posedge clk); #1;
    chk("rst_ready",   32'(pt.in_ready), 32'(0));
    chk("rst_rd_bank", 32'(rd_bank),     32'(1));
    chk("rst_len",     32'(frame_len),   32'(0));
    chk("rst_we",      32'(we),          32'(0));
    rst = 1;
    @(negedge clk); #1;
    chk("ready_pre_edge", 32'(pt.in_ready), 32'(0));
    @(posedge clk); #1;
    chk("ready_after", 32'(pt.in_ready), 32'(1));

    // three-point frame, then one more frame into the other bank
    clr_logs();
    send(8'h10, 8'h20, 0, 1, 0);
    send(8'h01, 8'h02, 1, 1, 0);
    send(8'h10, 8'h20, 1, 0, 1);
    idle(3);
    chk("t2_nwr",  32'(wa.size()), 32'(3));
    chk("t2_a0",   32'(wa[0]), 32'(0));
    chk("t2_a2",   32'(wa[2]), 32'(2));
    chk("t2_din0", 32'(wd[0]), 32'h08041);
    chk("t2_din2", 32'(wd[2]), 32'h08042);
    chk("t2_done", 32'(dn), 32'(1));
    chk("t2_rdb",  32'(rd_bank), 32'(0));
    chk("t2_len",  32'(frame_len), 32'(3));
    send(8'h03, 8'h04, 0, 0, 1);
    idle(3);
    chk("t2_a32",  32'(wa[3]), 32'(32));
    chk("t2_rdb2", 32'(rd_bank), 32'(1));
    chk("t2_len2", 32'(frame_len), 32'(1));

    // overflow: 40 points into a 32-entry bank
    clr_logs();
    for (int i = 0; i < 40; i++) send(8'(i), 8'(i), 1, 0, i == 39);
    pt.in_valid = 0;
    chk("t3_ovf",   32'(overflow), 32'(1));
    chk("t3_nodone", 32'(frame_done), 32'(0));
    @(posedge clk); #1;
    chk("t3_done",  32'(frame_done), 32'(1));
    chk("t3_ovf0",  32'(overflow), 32'(0));
    chk("t3_len",   32'(frame_len), 32'(32));
    chk("t3_rdb",   32'(rd_bank), 32'(0));
    idle(2);
    chk("t3_nwr",   32'(wa.size()), 32'(32));
    chk("t3_a31",   32'(wa[31]), 32'(31));
    chk("t3_din31", 32'(wd[31]), 32'h07C7E);

    // clear after five points, with a point pending during the clear
    clr_logs();
    for (int i = 0; i < 5; i++) send(8'(i+1), 8'h40, 0, 0, 0);
    pt.in_x = 8'h55; pt.in_y = 8'h66; pt.in_draw = 1; pt.in_pos = 0; pt.in_last = 0;
    clear = 1;
    @(negedge clk); #1;
    chk("t4_clr_ready", 32'(pt.in_ready), 32'(0));
    @(posedge clk); #1;
    clear = 0;
    chk("t4_rdb_keep", 32'(rd_bank), 32'(0));
    chk("t4_len_keep", 32'(frame_len), 32'(32));
    send(8'h55, 8'h66, 1, 0, 0);
    send(8'h77, 8'h88, 0, 1, 1);
    idle(3);
    chk("t4_nwr", 32'(wa.size()), 32'(7));
    chk("t4_a0",  32'(wa[0]), 32'(32));
    chk("t4_a4",  32'(wa[4]), 32'(36));
    chk("t4_a5",  32'(wa[5]), 32'(32));
    chk("t4_a6",  32'(wa[6]), 32'(33));
    chk("t4_len", 32'(frame_len), 32'(2));
    chk("t4_rdb", 32'(rd_bank), 32'(1));

`ifdef VECTOR_SWAP_SYNC_EN
    // sync swap: an early rd_wrap is ignored, a later one commits
    send(8'h01, 8'h01, 1, 0, 0);
    rd_wrap = 1;
    send(8'h02, 8'h02, 1, 0, 0);
    rd_wrap = 0;
    send(8'h03, 8'h03, 1, 0, 1);
    pt.in_valid = 0;
    lowcnt = 0; mon = 1;
    repeat (6) begin @(posedge clk); #1; end
    chk("t5_wait_done", 32'(frame_done), 32'(0));
    chk("t5_wait_rdb",  32'(rd_bank), 32'(1));
    rd_wrap = 1;
    @(posedge clk); #1;
    rd_wrap = 0; mon = 0;
    chk("t5_done",  32'(frame_done), 32'(1));
    chk("t5_rdb",   32'(rd_bank), 32'(0));
    chk("t5_len",   32'(frame_len), 32'(3));
    chk("t5_bubble", 32'(lowcnt), 32'(7));
    send(8'h05, 8'h05, 1, 1, 1);
    rd_wrap = 1; pt.in_valid = 0;
    @(posedge clk); #1;
    rd_wrap = 0;
    chk("t5_fast_done", 32'(frame_done), 32'(1));
    chk("t5_fast_rdb",  32'(rd_bank), 32'(1));
    chk("t5_fast_len",  32'(frame_len), 32'(1));
    idle(2);
`else
    // back-to-back frames with in_valid held; rd_wrap pulses have no effect
    clr_logs();
    lowcnt = 0; mon = 1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 3; i++) begin
        rd_wrap = (i == 1);
        send(8'(f*3+i), 8'(f), 1, 0, i == 2);
      end
    rd_wrap = 0; pt.in_valid = 0;
    @(posedge clk); #1;
    mon = 0;
    idle(2);
    chk("t6_bubbles", 32'(lowcnt), 32'(3));
    chk("t6_ndone",   32'(dbank.size()), 32'(3));
    chk("t6_bank0",   32'(dbank[0]), 32'(0));
    chk("t6_bank1",   32'(dbank[1]), 32'(1));
    chk("t6_bank2",   32'(dbank[2]), 32'(0));
    chk("t6_a_last",  32'(wa[8]), 32'(2));
`endif

    // reset mid-frame discards the partial frame
    clr_logs();
    send(8'h09, 8'h09, 1, 0, 0);
    send(8'h0A, 8'h0A, 1, 0, 0);
    pt.in_valid = 0;
    rst = 0;
    #2;
    chk("mid_rst_rdb", 32'(rd_bank), 32'(1));
    chk("mid_rst_len", 32'(frame_len), 32'(0));
    chk("mid_rst_we",  32'(we), 32'(0));
    @(posedge clk); #1;
    rst = 1;
    idle(2);
    send(8'h0B, 8'h0C, 0, 1, 1);
    idle(3);
    chk("mid_rst_a",   32'(wa[wa.size()-1]), 32'(0));
    chk("mid_rst_len1", 32'(frame_len), 32'(1));
    chk("mid_rst_rdb0", 32'(rd_bank), 32'(0));

    cmp_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
